// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg: shared types and default widths for the UART Wishbone master.
package uart_wb_pkg;
  localparam int UART_ADDR_W = 5;
  localparam int UART_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef struct packed {
    logic                   we;
    logic [UART_ADDR_W-1:0] adr;
    logic [UART_DATA_W-1:0] dat;
    logic [3:0]             sel;
  } wb_cmd_t;
endpackage

// File: rtl/uart_wb_master_if.sv
// uart_wb_master_if: command, response and Wishbone signals of the UART bus master.
interface uart_wb_master_if import uart_wb_pkg::*; #(
  parameter int ADDR_W = UART_ADDR_W,
  parameter int DATA_W = UART_DATA_W
) ();
  logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [ADDR_W-1:0] cmd_adr_i;
  logic [DATA_W-1:0] cmd_dat_i;
  logic [3:0]        cmd_sel_i;
  logic              rsp_valid_o, rsp_ready_i, rsp_we_o;
  logic [DATA_W-1:0] rsp_dat_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o, wb_dat_i;
  logic              wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic [3:0]        wb_sel_o;
  logic              wb_stall_o, err_spurious_o;
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, wb_dat_i, wb_ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_we_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
           wb_stb_o, wb_cyc_o, wb_stall_o, err_spurious_o
  );
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, wb_dat_i, wb_ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_we_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
           wb_stb_o, wb_cyc_o, wb_stall_o, err_spurious_o
  );
endinterface

// File: rtl/uart_wb_master.sv
// uart_wb_master: one Wishbone classic single cycle per command, response returned on valid/ready.
module uart_wb_master import uart_wb_pkg::*; #(
  parameter int ADDR_W      = UART_ADDR_W,
  parameter int DATA_W      = UART_DATA_W,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  uart_wb_master_if.master bus
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STALL_LIMIT);
  state_t            r_state, w_next;
  wb_cmd_t           r_cmd;
  logic [DATA_W-1:0] r_rsp_dat;
  logic              r_rsp_we, r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_bus, w_done;
  assign w_bus  = r_state == BUS;
  assign w_done = w_bus && bus.wb_ack_i;
  always_ff @(posedge wb_clk_i)
    r_state <= wb_rst_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = bus.cmd_valid_i ? BUS : IDLE;
      BUS:     w_next = bus.wb_ack_i ? RESP : BUS;
      RESP:    w_next = bus.rsp_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.cmd_ready_o = r_state == IDLE;
    bus.wb_cyc_o    = w_bus;
    bus.wb_stb_o    = w_bus;
    bus.rsp_valid_o = r_state == RESP;
    bus.wb_stall_o  = w_bus && r_cnt >= LIM;
  end
  assign bus.wb_adr_o       = ADDR_W'(r_cmd.adr);
  assign bus.wb_dat_o       = DATA_W'(r_cmd.dat);
  assign bus.wb_we_o        = r_cmd.we;
  assign bus.wb_sel_o       = r_cmd.sel;
  assign bus.rsp_dat_o      = r_rsp_dat;
  assign bus.rsp_we_o       = r_rsp_we;
  assign bus.err_spurious_o = r_err;
  // counter saturates rather than wrapping so a long stall never looks recovered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cmd     <= '0;
      r_rsp_dat <= '0;
      r_rsp_we  <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.cmd_valid_i)
        r_cmd <= '{we: bus.cmd_we_i, adr: bus.cmd_adr_i, dat: bus.cmd_dat_i, sel: bus.cmd_sel_i};
      if (w_done) begin
        r_rsp_dat <= r_cmd.we ? '0 : bus.wb_dat_i;
        r_rsp_we  <= r_cmd.we;
      end
      r_cnt <= (w_bus && !bus.wb_ack_i) ? r_cnt + {{(CNT_W-1){1'b0}}, ~&r_cnt} : '0;
      if (bus.wb_ack_i && !w_bus) r_err <= 1'b1;
    end
  end
endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Upstream Wishbone bus master that drives the UART register interface (uart_top wb_* inputs).
- Accepts register read/write commands over a valid/ready port and issues one Wishbone classic single cycle per command.
- Returns read data, or a write completion, on a valid/ready response port.
- Bus behaviour is legal by construction against the UART Wishbone interface constraints (see Behaviour).

Parameters:
- ADDR_W, 5, Wishbone address width (matches UART_ADDR_WIDTH).
- DATA_W, 32, Wishbone data width (matches UART_DATA_WIDTH).
- STALL_LIMIT, 64, cycles waiting for ack before wb_stall_o asserts.
- CNT_W, 8, stall counter width; must satisfy 2**CNT_W > STALL_LIMIT.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&&ready at posedge.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  ADDR_W  register address.
- cmd_dat_i  in  DATA_W  write data.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  DATA_W  read data; 0 for writes.
- rsp_we_o  out  1  echo of the command's we.
- wb_adr_o  out  ADDR_W  Wishbone address.
- wb_dat_o  out  DATA_W  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_stall_o  out  1  ack wait has reached STALL_LIMIT.
- err_spurious_o  out  1  sticky: ack seen outside an active strobe.

Behaviour:
- Clocking and reset:
  - Single clock wb_clk_i; all state updates on posedge.
  - wb_rst_i is synchronous and active-high.
  - Reset values: state IDLE, all outputs 0 except cmd_ready_o=1 (IDLE). Includes wb_cyc_o, wb_stb_o, rsp_valid_o, stall counter, err_spurious_o.
- FSM states IDLE, BUS, RESP:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch we/adr/dat/sel into wb_*_o and go to BUS; wb_cyc_o=wb_stb_o=1 from the next cycle.
  - BUS: cyc=stb=1. wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o hold stable every cycle until ack. The stall counter increments each cycle without ack, saturating at all-ones.
  - BUS with wb_ack_i sampled high: capture rsp_dat_o = wb_we_o ? 0 : wb_dat_i, set rsp_we_o, go to RESP. Next cycle cyc=stb=0 and rsp_valid_o=1. Counter clears.
  - RESP: rsp_valid_o holds; rsp_dat_o and rsp_we_o are stable. When rsp_ready_i is high, go to IDLE with rsp_valid_o=0 next cycle. cmd_ready_o=0 in BUS and RESP.
- Bus legality:
  - wb_stb_o is never high without wb_cyc_o; both are driven from the same state decode.
  - stb never drops before ack; there is no abort path, including on stall.
  - cyc and stb return to 0 for at least one cycle between transactions.
- Latency:
  - Accept at edge T; cyc/stb high during cycle T+1.
  - With ack on the first bus cycle, rsp_valid_o is high in cycle T+2.
  - Minimum 3 cycles per command when rsp_ready_i is held high.
- wb_stall_o = (counter >= STALL_LIMIT) while in BUS; 0 otherwise. Status only; the transaction keeps waiting.
- wb_ack_i high while not in BUS: ignored for data; sets err_spurious_o, which clears only on reset.
- cmd_valid_i in BUS/RESP: no effect (not accepted); the upstream holds it.
- Reset mid-transaction: next edge forces IDLE with all bus outputs 0. The pending command and response are discarded.

Decomposition:
- Package uart_wb_pkg: state enum (IDLE, BUS, RESP), wb_cmd_t struct {we, adr, dat, sel}, and default width constants tied to the UART defines.
- No sub-module; the single FSM plus command register and counter fits in about 150–200 lines.

Test Plan:
- Write: cmd we=1, adr=0x03, dat=0x83, sel=0xF; ack on first bus cycle → cyc/stb high for 1 cycle with adr 0x03, dat 0x83; rsp_valid two cycles after accept; rsp_dat=0, rsp_we=1.
- Read with wait states: adr=0x05, ack after 4 cycles with wb_dat_i=0x60 → adr/we/sel stable for all 4 cycles, stb never drops; rsp_dat=0x60.
- Stall: withhold ack for 70 cycles, STALL_LIMIT=64 → wb_stall_o rises on stall cycle 64, stb stays high; ack clears wb_stall_o and completes normally.
- Response backpressure: rsp_ready=0 for 5 cycles with a second cmd_valid pending → cmd_ready=0 throughout; second command accepted only the cycle after rsp handshake, with a cyc-low gap between transactions.
- Spurious ack: wb_ack_i=1 in IDLE → err_spurious_o=1 and sticky; no rsp_valid produced.
- Reset mid-BUS: assert wb_rst_i in wait cycle 2 → next cycle cyc=stb=0, rsp_valid=0, cmd_ready=1, counter=0.
